// File: rtl/serial_parity_deserializer_pkg.sv
// serial_parity_pkg: state encoding, default width and parity helper shared by
// the parity link RTL and its bench.
package serial_parity_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [0:0] {ST_COLLECT = 1'b0, ST_FULL = 1'b1} state_e;
    // Parity bit that makes XOR(word[width-1:0], parity) equal to odd.
    function automatic logic exp_parity(input logic [63:0] word, input int width, input logic odd);
        logic p;
        p = odd;
        for (int k = 0; k < 64; k++) p = (k < width) ? p ^ word[k] : p;
        return p;
    endfunction
endpackage

// File: rtl/serial_parity_deserializer_if.sv
// serial_parity_deserializer_if: serial bit input and parallel word output
// handshakes of the parity deserializer.
interface serial_parity_deserializer_if import serial_parity_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic in_valid, in_ready, in_bit, out_valid, out_ready, out_parity_err;
    logic [WIDTH-1:0] out_data;
    modport master(output in_valid, in_bit, out_ready, input in_ready, out_valid, out_data, out_parity_err);
    modport slave(input in_valid, in_bit, out_ready, output in_ready, out_valid, out_data, out_parity_err);
endinterface

// File: rtl/serial_parity_deserializer_accum.sv
// parity_accum: 1-bit running XOR with clear (priority) and enable, shared
// with the matching transmitter.
module parity_accum import serial_parity_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);
    logic q_q, q_d;
    always_comb q_d = clr_i ? 1'b0 : en_i ? q_q ^ d_i : q_q;
    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= q_d;
    end
    assign q_o = q_q;
endmodule

// File: rtl/serial_parity_deserializer.sv
// serial_parity_deserializer: rebuilds LSB-first serial frames plus parity bit
// into words; `define PARITY_ERR_DROP_EN to drop errored frames with an error pulse.
module serial_parity_deserializer import serial_parity_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic clk,
    input logic rst_n,
    serial_parity_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [0:0] COLLECT = ST_COLLECT;
    localparam logic [0:0] FULL = ST_FULL;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [0:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic err_q, err_d, acc, in_beat, par_beat, bad, deliver;

    assign bus.in_ready = (state_q == COLLECT) || bus.out_ready;
    assign bus.out_valid = state_q == FULL;
    assign bus.out_data = data_q;
    assign bus.out_parity_err = err_q;
    assign in_beat = bus.in_valid && bus.in_ready;
    assign par_beat = in_beat && (cnt_q == LAST);
    assign bad = (acc ^ bus.in_bit) != ODD_PARITY;
`ifdef PARITY_ERR_DROP_EN
    assign deliver = par_beat && !bad;
`else
    assign deliver = par_beat;
`endif

    parity_accum u_acc (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(par_beat),
        .en_i (in_beat),
        .d_i  (bus.in_bit),
        .q_o  (acc)
    );

    // Data bits enter at the top so the first bit lands in bit 0 after WIDTH beats.
    always_comb begin
        state_d = deliver ? FULL : (bus.out_valid && bus.out_ready) ? COLLECT : state_q;
        cnt_d = !in_beat ? cnt_q : par_beat ? '0 : cnt_q + CW'(1);
        shift_d = (in_beat && !par_beat) ? {bus.in_bit, shift_q[WIDTH-1:1]} : shift_q;
        data_d = deliver ? shift_q : data_q;
`ifdef PARITY_ERR_DROP_EN
        err_d = par_beat && bad;
`else
        err_d = par_beat ? bad : err_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            data_q <= data_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_serial_parity_deserializer.sv
// tb_serial_parity_deserializer: drives an even-parity and an odd-parity instance
// with directed then random traffic against a frame-level reference model.
module tb_serial_parity_deserializer;
    import serial_parity_pkg::*;
    localparam int W = 8;
`ifdef PARITY_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] in_valid, in_bit, out_ready, in_ready, out_valid, out_err;
    logic [W-1:0] out_data [2];

    serial_parity_deserializer_if #(.WIDTH(W)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign bus[g].in_valid = in_valid[g];
        assign bus[g].in_bit = in_bit[g];
        assign bus[g].out_ready = out_ready[g];
        assign in_ready[g] = bus[g].in_ready;
        assign out_valid[g] = bus[g].out_valid;
        assign out_data[g] = bus[g].out_data;
        assign out_err[g] = bus[g].out_parity_err;
        serial_parity_deserializer #(.WIDTH(W), .ODD_PARITY(g == 1)) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int n [2];
    logic [W-1:0] frame [2];
    logic [W-1:0] pdata [2];
    bit pend [2];
    bit perr [2];
    bit pulse [2];
    bit fresh [2];
    logic dbits [$];
    int dptr [2];
    int stall [2];
    bit directed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d, input logic par);
        for (int k = 0; k < W; k++) dbits.push_back(d[k]);
        dbits.push_back(par);
    endtask

    // Reference: bits collect into a frame; the WIDTH+1-th bit closes it and
    // either hands it to the output slot or (drop build, bad parity) pulses err.
    task automatic model_step();
        bit rdy, bad;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                n[i] = 0; frame[i] = '0; pend[i] = 0; pdata[i] = '0;
                perr[i] = 0; pulse[i] = 0; fresh[i] = 1;
            end else begin
                rdy = !pend[i] || out_ready[i];
                pulse[i] = 0;
                fresh[i] = 0;
                if (pend[i] && out_ready[i]) pend[i] = 0;
                if (in_valid[i] && rdy) begin
                    if (directed && dptr[i] < dbits.size()) dptr[i]++;
                    if (n[i] < W) begin
                        frame[i][n[i]] = in_bit[i];
                        n[i]++;
                    end else begin
                        bad = ((^frame[i]) ^ in_bit[i]) != (i == 1);
                        n[i] = 0;
                        if (DROP && bad) pulse[i] = 1;
                        else begin
                            pend[i] = 1; pdata[i] = frame[i]; perr[i] = bad;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("out_valid%0d", i), out_valid[i], pend[i]);
            if (pend[i] || fresh[i]) begin
                check($sformatf("out_data%0d", i), out_data[i], pdata[i]);
                check($sformatf("out_err%0d", i), out_err[i], perr[i]);
            end else if (DROP) check($sformatf("err_pulse%0d", i), out_err[i], pulse[i]);
        end
    endtask

    task automatic drive();
        bit hold;
        for (int i = 0; i < 2; i++) begin
            if (directed) begin
                in_valid[i] = dptr[i] < dbits.size();
                in_bit[i] = in_valid[i] ? dbits[dptr[i]] : 1'b0;
                hold = pend[i] && pdata[i] == 8'h3C && stall[i] < 5;
                if (hold) stall[i]++;
                out_ready[i] = !hold;
            end else begin
                in_valid[i] = $urandom_range(0, 9) < 7;
                in_bit[i] = 1'($urandom_range(0, 1));
                out_ready[i] = $urandom_range(0, 9) < 7;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        drive();
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("in_ready%0d", i), in_ready[i], !pend[i] || out_ready[i]);
    endtask

    initial begin
        in_valid = '0; in_bit = '0; out_ready = '0;
        directed = 1;
        dptr = '{0, 0};
        stall = '{0, 0};
        push_frame(8'hA5, exp_parity(64'hA5, W, 1'b0));
        push_frame(8'hA5, ~exp_parity(64'hA5, W, 1'b0));
        push_frame(8'h3C, exp_parity(64'h3C, W, 1'b0));
        push_frame(8'h3C, exp_parity(64'h3C, W, 1'b0));
        push_frame(8'hFF, exp_parity(64'hFF, W, 1'b0));
        push_frame(8'h00, 1'b1);
        push_frame(8'h00, 1'b0);
        dbits.push_back(1'b1); dbits.push_back(1'b0); dbits.push_back(1'b1); dbits.push_back(1'b1);
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 600 && (dptr[0] < dbits.size() || dptr[1] < dbits.size()); c++) cycle();
        check("dir_done0", dptr[0], dbits.size());
        check("dir_done1", dptr[1], dbits.size());
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        push_frame(8'h81, 1'b0);
        for (int c = 0; c < 100 && (dptr[0] < dbits.size() || dptr[1] < dbits.size()); c++) cycle();
        check("rst_frame0", dptr[0], dbits.size());
        check("rst_frame1", dptr[1], dbits.size());
        repeat (4) cycle();
        directed = 0;
        repeat (4000) begin
            rst_n = $urandom_range(0, 599) != 0;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
